// File: rtl/dmem_store_buffer.sv
// Data-memory stage: word-addressed single-port RAM fed by an in-order store buffer,
// with combinational loads forwarded from the youngest buffered store. Optional counters: DMEM_STATS_EN.
module dmem_store_buffer #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 7,
  parameter int SB_DEPTH    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic [106:0]                mem_e,
  output logic [31:0]                 memory_o,
  output logic [$clog2(SB_DEPTH):0]   sb_count_o,
  output logic                        sb_empty_o,
  output logic [15:0]                 stat_fwd_o,
  output logic [15:0]                 stat_store_o
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              memread, memwrite;
  logic              is_load, is_store;
  logic [31:0]       address, st_data;
  logic [ADDR_W-1:0] index;

  assign memread  = mem_e[103];
  assign memwrite = mem_e[102];
  assign address  = mem_e[68:37];
  assign st_data  = mem_e[36:5];
  assign index    = address[ADDR_W+1:2];
  assign is_store = memwrite;
  assign is_load  = memread & ~memwrite;

  logic unused_bits;
  assign unused_bits = ^{mem_e[106:104], mem_e[101:69], mem_e[4:0],
                         address[31:ADDR_W+2], address[1:0]};

  logic [31:0]       ram     [DEPTH_WORDS];
  logic [ADDR_W-1:0] sb_idx  [SB_DEPTH];
  logic [31:0]       sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              push, pop;

  // The single RAM port belongs to the load whenever one is present; drain waits.
  assign push = is_store;
  assign pop  = (count != '0) && !is_load;

  // NOTE: the RAM is cleared by reset, so every word is a flop with async clear
  // rather than an inferred memory macro; drop the reset loop to get a macro.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) ram[i] <= '0;
    end else if (pop) begin
      ram[sb_idx[head]] <= sb_data[head];
    end
  end

  // NOTE: non-blocking assignments let push and pop both touch the head slot
  // of a full buffer in one edge: RAM takes the old entry, the slot the new one.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_idx[i]  <= '0;
        sb_data[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        sb_idx[tail]  <= index;
        sb_data[tail] <= st_data;
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic        fwd_hit;
  logic [31:0] fwd_data;

  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  // Scanning oldest to youngest leaves the youngest match in fwd_data.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (sb_idx[head + PTR_W'(i)] == index)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[head + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    memory_o = '0;
    if (is_load) memory_o = fwd_hit ? fwd_data : ram[index];
  end

  assign sb_count_o = count;
  assign sb_empty_o = (count == '0);

`ifdef DMEM_STATS_EN
  logic [15:0] fwd_cnt, store_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt   <= '0;
      store_cnt <= '0;
    end else begin
      if (push && store_cnt != 16'hFFFF)               store_cnt <= store_cnt + 1'b1;
      if (is_load && fwd_hit && fwd_cnt != 16'hFFFF)   fwd_cnt   <= fwd_cnt + 1'b1;
    end
  end

  assign stat_fwd_o   = fwd_cnt;
  assign stat_store_o = store_cnt;
`else
  assign stat_fwd_o   = '0;
  assign stat_store_o = '0;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed scenarios plus random traffic
// against a queue-based reference model of the buffer and a plain array for RAM.
module tb_dmem_store_buffer;

  localparam int K_IDLE  = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BOTH  = 3;

  logic         clk_i;
  logic         rst_n;
  logic [106:0] mem_e;
  logic [31:0]  memory_o;
  logic [2:0]   sb_count_o;
  logic         sb_empty_o;
  logic [15:0]  stat_fwd_o;
  logic [15:0]  stat_store_o;

  dmem_store_buffer dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .mem_e        (mem_e),
    .memory_o     (memory_o),
    .sb_count_o   (sb_count_o),
    .sb_empty_o   (sb_empty_o),
    .stat_fwd_o   (stat_fwd_o),
    .stat_store_o (stat_store_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0]  idx;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_ram [128];
  ent_t        m_q [$];
  int          m_fwd, m_store;
  int          n_checks, n_errors;
  logic [31:0] obs_mem;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_ram[i]) m_ram[i] = '0;
    m_q.delete();
    m_fwd   = 0;
    m_store = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef DMEM_STATS_EN
    check({tag, "_stat_fwd"},   32'(stat_fwd_o),   32'(m_fwd));
    check({tag, "_stat_store"}, 32'(stat_store_o), 32'(m_store));
`else
    check({tag, "_stat_fwd"},   32'(stat_fwd_o),   32'd0);
    check({tag, "_stat_store"}, 32'(stat_store_o), 32'd0);
`endif
  endtask

  // Called at a falling edge; applies one bundle for one full cycle.
  task automatic op(input int kind, input logic [31:0] addr, input logic [31:0] data);
    logic [127:0] junk;
    logic         ld, st, hit;
    logic [6:0]   idx;
    logic [31:0]  exp_mem;
    junk = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem_e = junk[106:0];
    mem_e[103]   = (kind == K_LOAD) || (kind == K_BOTH);
    mem_e[102]   = (kind == K_STORE) || (kind == K_BOTH);
    mem_e[68:37] = addr;
    mem_e[36:5]  = data;
    ld  = (kind == K_LOAD);
    st  = (kind == K_STORE) || (kind == K_BOTH);
    idx = addr[8:2];
    hit = 1'b0;
    exp_mem = '0;
    if (ld) begin
      exp_mem = m_ram[idx];
      for (int i = m_q.size() - 1; i >= 0; i--) begin
        if (m_q[i].idx == idx) begin
          exp_mem = m_q[i].data;
          hit = 1'b1;
          break;
        end
      end
    end
    #1;
    obs_mem = memory_o;
    check("memory_o", memory_o, exp_mem);
    check("sb_count", 32'(sb_count_o), 32'(m_q.size()));
    check("sb_empty", 32'(sb_empty_o), 32'(m_q.size() == 0));
    check_stats("op");
    @(posedge clk_i);
    if (!ld && m_q.size() > 0) begin
      m_ram[m_q[0].idx] = m_q[0].data;
      void'(m_q.pop_front());
    end
    if (st) begin
      m_q.push_back('{idx: idx, data: data});
      if (m_store < 16'hFFFF) m_store++;
    end
    if (ld && hit && m_fwd < 16'hFFFF) m_fwd++;
    @(negedge clk_i);
  endtask

  // Called at a falling edge; holds reset across one rising edge.
  task automatic do_reset(input logic [31:0] load_addr);
    mem_e = '0;
    mem_e[103] = 1'b1;
    mem_e[68:37] = load_addr;
    rst_n = 1'b0;
    #2;
    check("rst_memory_o", memory_o, 32'd0);
    check("rst_sb_count", 32'(sb_count_o), 32'd0);
    check("rst_sb_empty", 32'(sb_empty_o), 32'd1);
    model_clear();
    check_stats("rst");
    @(negedge clk_i);
    rst_n = 1'b1;
    mem_e = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    mem_e = '0;
    model_clear();
    @(negedge clk_i);
    do_reset(32'h10);
    @(negedge clk_i);

    op(K_LOAD, 32'h10, 0);
    check("reset_load_0x10", obs_mem, 32'd0);

    op(K_STORE, 32'h20, 32'hDEADBEEF);
    op(K_LOAD,  32'h20, 0);
    check("deadbeef_fwd", obs_mem, 32'hDEADBEEF);
    op(K_IDLE, 0, 0);
    op(K_LOAD, 32'h20, 0);
    check("deadbeef_ram", obs_mem, 32'hDEADBEEF);

    op(K_STORE, 32'h40, 32'h1);
    op(K_STORE, 32'h40, 32'h2);
    op(K_STORE, 32'h40, 32'h3);
    op(K_LOAD,  32'h40, 0);
    check("youngest_match", obs_mem, 32'h3);
    op(K_IDLE, 0, 0);
    op(K_IDLE, 0, 0);
    op(K_LOAD, 32'h40, 0);
    check("youngest_ram", obs_mem, 32'h3);

    for (int i = 0; i < 5; i++) begin
      op(K_STORE, 32'h80 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      op(K_LOAD,  32'h80 + 32'(4 * i), 0);
    end
    op(K_BOTH, 32'h200 + 32'h94, 32'h5555_AAAA);
    for (int i = 0; i < 5; i++) begin
      op(K_LOAD, 32'h80 + 32'(4 * i), 0);
      check("five_readable", obs_mem, 32'hC0DE_0000 + 32'(i));
    end
    op(K_LOAD, 32'h94, 0);
    check("alias_store_wins", obs_mem, 32'h5555_AAAA);

    op(K_STORE, 32'h08, 32'hAA);
    do_reset(32'h08);
    op(K_LOAD, 32'h08, 0);
    check("post_reset_0x08", obs_mem, 32'd0);

    op(K_STORE, 32'h04, 32'h11);
    op(K_STORE, 32'h08, 32'h22);
    op(K_STORE, 32'h0C, 32'h33);
    op(K_LOAD,  32'h0C, 0);
    op(K_LOAD,  32'h0C, 0);
    op(K_LOAD,  32'h04, 0);
    check("stats_ram_load", obs_mem, 32'h11);
`ifdef DMEM_STATS_EN
    check("stats_store_3", 32'(stat_store_o), 32'd3);
    check("stats_fwd_2",   32'(stat_fwd_o),   32'd2);
`else
    check("stats_store_off", 32'(stat_store_o), 32'd0);
    check("stats_fwd_off",   32'(stat_fwd_o),   32'd0);
`endif

    for (int i = 0; i < 2000; i++) begin
      int          r, kind;
      logic [31:0] a;
      if (i == 1000) do_reset($urandom());
      r = int'($urandom_range(0, 99));
      kind = (r < 40) ? K_LOAD : (r < 75) ? K_STORE : (r < 85) ? K_BOTH : K_IDLE;
      a = $urandom();
      a[8:2] = 7'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a[8:2] = 7'($urandom());
      op(kind, a, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
